// File: rtl/sr_pkg.sv
// Shared constants for the serial/parallel converter pair (SIPO loader and downstream PISO).
package sr_pkg;

  localparam int unsigned SR_WIDTH = 16;
  localparam int unsigned SR_CNT_W = $clog2(SR_WIDTH);

  // Bit-counter width for an arbitrary word width (never below one bit).
  function automatic int unsigned sr_cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out loader: assembles MSB-first words from sin and presents
// them through a one-entry holding register with valid/ready handshake.
module sipo_loader
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = SR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = sr_cnt_w(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_take;

  assign w_word = {r_sreg[WIDTH-2:0], sin};
  assign w_done = sin_valid && (r_cnt == CW'(WIDTH - 1));
  // A completing word may replace a word that is being consumed on the same edge.
  assign w_take = w_done && (!r_pout_valid || pout_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_sreg       <= '0;
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (clr) begin
      r_cnt        <= '0;
      r_sreg       <= '0;
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (sin_valid) begin
        r_sreg <= w_word;
        r_cnt  <= w_done ? '0 : r_cnt + CW'(1);
      end
      if (w_take) begin
        r_pout       <= w_word;
        r_pout_valid <= 1'b1;
      end else if (w_done) begin
        r_overrun <= 1'b1;
      end else if (r_pout_valid && pout_ready) begin
        r_pout_valid <= 1'b0;
      end
    end
  end

  assign pout       = r_pout;
  assign pout_valid = r_pout_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_cnt != '0);

endmodule

// File: tb/tb_sipo_loader.sv
// Directed and randomized checks of sipo_loader against a word-level reference model.
module tb_sipo_loader;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         pout_ready = 1'b0;
  logic [W-1:0] pout;
  logic         pout_valid;
  logic         busy;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state: bits received in the current word, the partial word value,
  // the held word and flags.
  int m_nbits = 0;
  int m_acc   = 0;
  int m_pout  = 0;
  bit m_pv    = 0;
  bit m_ovr   = 0;

  sipo_loader #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nbits = 0; m_acc = 0; m_pout = 0; m_pv = 0; m_ovr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pout"},  32'(pout),       32'(m_pout));
    chk({tag, "_pv"},    32'(pout_valid), 32'(m_pv));
    chk({tag, "_busy"},  32'(busy),       32'(m_nbits != 0));
    chk({tag, "_ovr"},   32'(overrun),    32'(m_ovr));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 ns later.
  task automatic step(input bit b, input bit v, input bit rdy, input bit c, input string tag);
    bit done;
    @(negedge clk);
    sin = b; sin_valid = v; pout_ready = rdy; clr = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      done = v && (m_nbits == W - 1);
      if (v) begin
        m_acc   = (m_acc * 2 + int'(b)) % (1 << W);
        m_nbits = (m_nbits + 1) % W;
      end
      if (done) begin
        if (!m_pv || rdy) begin
          m_pout = m_acc; m_pv = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_pv && rdy) begin
        m_pv = 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  // Send a word MSB first; ready is held at rdy except on the last bit, where rdy_last is used.
  task automatic send(input logic [W-1:0] w, input bit rdy, input bit rdy_last, input string tag);
    for (int i = W - 1; i >= 0; i--)
      step(w[i], 1'b1, (i == 0) ? rdy_last : rdy, 1'b0, tag);
  endtask

  // Asynchronous reset pulse inside a clock low phase; outputs must clear without an edge.
  task automatic pulse_rst(input string tag);
    @(negedge clk);
    sin_valid = 1'b0; clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_async_pout"}, 32'(pout), 32'h0);
    chk({tag, "_async_pv"},   32'(pout_valid), 32'h0);
    chk({tag, "_async_busy"}, 32'(busy), 32'h0);
    chk({tag, "_async_ovr"},  32'(overrun), 32'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;

    // Reset state
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 0xA5C3 back to back with ready high: valid for exactly one cycle
    send(16'hA5C3, 1'b1, 1'b1, "a5c3");
    chk("a5c3_word", 32'(pout), 32'h0000A5C3);
    chk("a5c3_valid", 32'(pout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, "a5c3_drain");
    chk("a5c3_one_cycle", 32'(pout_valid), 32'h0);

    // 0x1234 with gaps: busy throughout bits 1..15
    w = 16'h1234;
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1, 1'b0, 1'b0, "gap_bit");
      if (i != 0) chk("gap_busy", 32'(busy), 32'h1);
      step(1'b1, 1'b0, 1'b0, 1'b0, "gap_idle");
    end
    chk("gap_word", 32'(pout), 32'h00001234);
    step(1'b0, 1'b0, 1'b1, 1'b0, "gap_drain");

    // Stall: second word is dropped and overrun sets
    send(16'hFFFF, 1'b0, 1'b0, "stall1");
    send(16'h0001, 1'b0, 1'b0, "stall2");
    chk("stall_word", 32'(pout), 32'h0000FFFF);
    chk("stall_valid", 32'(pout_valid), 32'h1);
    chk("stall_overrun", 32'(overrun), 32'h1);

    // clr with sin_valid while overrun and valid are set
    step(1'b1, 1'b1, 1'b0, 1'b1, "clr");
    chk("clr_pout", 32'(pout), 32'h0);
    chk("clr_valid", 32'(pout_valid), 32'h0);
    chk("clr_overrun", 32'(overrun), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);

    // Ready on the same edge as the next completion: no overrun
    send(16'h00FF, 1'b0, 1'b0, "same1");
    send(16'hF00F, 1'b0, 1'b1, "same2");
    chk("same_word", 32'(pout), 32'h0000F00F);
    chk("same_valid", 32'(pout_valid), 32'h1);
    chk("same_overrun", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "same_drain");

    // Reset after 7 bits, then a clean word
    for (int i = 0; i < 7; i++) step(1'($urandom_range(1)), 1'b1, 1'b1, 1'b0, "partial");
    pulse_rst("midrst");
    send(16'hBEEF, 1'b1, 1'b1, "beef");
    chk("beef_word", 32'(pout), 32'h0000BEEF);
    chk("beef_valid", 32'(pout_valid), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(199) == 0) pulse_rst("rnd_rst");
      step(1'($urandom_range(1)), ($urandom_range(9) < 7), ($urandom_range(1) == 1),
           ($urandom_range(49) == 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
